// File: rtl/event_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// event_tx_scheduler_if
//   Bundles the event inputs, the UART transmitter handshake and the status
//   outputs of event_tx_scheduler.
//   master : side that drives en/req/tx_busy and observes the scheduler
//   slave  : the scheduler itself
//   Signals:
//     en         1 = capture and send events, 0 = drop/clear
//     req[3:0]   per-source event pulses
//     tx_busy    TxD_busy from the transmitter
//     tx_start   TxD_start, 1-cycle pulse
//     tx_data    TxD_data, held between starts
//     frame_sent 1-cycle pulse after the last byte of a frame finished
//     active     scheduler is not idle
//     drop_cnt   events lost to a still-pending slot (saturating)
// ---------------------------------------------------------------------------
interface event_tx_scheduler_if;
    logic       en;
    logic [3:0] req;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       frame_sent;
    logic       active;
    logic [7:0] drop_cnt;

    modport master (
        output en, req, tx_busy,
        input  tx_start, tx_data, frame_sent, active, drop_cnt
    );

    modport slave (
        input  en, req, tx_busy,
        output tx_start, tx_data, frame_sent, active, drop_cnt
    );
endinterface

// File: rtl/event_tx_scheduler.sv
// ---------------------------------------------------------------------------
// event_tx_scheduler
//   Shares one UART transmitter between four event sources. Each event is
//   timestamped on arrival into a one-deep slot per source; a round-robin
//   arbiter sends pending events as 3-byte frames:
//     B0 = {HEADER, 2'b00, id}, B1 = ts[7:0], B2 = ts[15:8]
//   Ports:
//     clk_fast  clock, all logic on posedge
//     rst       synchronous active-high reset
//     bus       event_tx_scheduler_if.slave (en, req, tx_busy in;
//               tx_start, tx_data, frame_sent, active, drop_cnt out)
//   Parameters:
//     TICK_DIV  clk_fast cycles per timestamp tick (2..65535)
//     HEADER    frame sync nibble in byte 0
// ---------------------------------------------------------------------------
module event_tx_scheduler #(
    parameter logic [15:0] TICK_DIV = 16'd50000,
    parameter logic [3:0]  HEADER   = 4'hA
) (
    input  logic                 clk_fast,
    input  logic                 rst,
    event_tx_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_WAIT} state_t;

    state_t      state;
    logic [15:0] tick_cnt;
    logic [15:0] ts;
    logic [3:0]  pending;
    logic [15:0] slot_ts [4];
    logic [1:0]  rr_ptr;
    logic [1:0]  byte_idx;
    logic [7:0]  frame_b1;
    logic [7:0]  frame_b2;

    logic        found;
    logic        grant;
    logic [1:0]  winner;
    logic [1:0]  cand;
    logic [2:0]  lost;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {6'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Round-robin search starts just after the last winner; k=4 wraps back
    // to rr_ptr itself so a lone requester can win repeatedly.
    always_comb begin
        found  = 1'b0;
        winner = rr_ptr;
        cand   = rr_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = rr_ptr + 2'(k);
            if (!found && pending[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        grant = (state == S_IDLE) && bus.en && found && !bus.tx_busy;
    end

    // A request hitting a full slot is lost, unless that slot is being
    // granted in the same cycle (the grant frees it for the new event).
    always_comb begin
        lost = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.req[i] && bus.en && pending[i] && !(grant && winner == 2'(i)))
                lost = lost + 3'd1;
        end
    end

    assign bus.active = (state != S_IDLE);

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state          <= S_IDLE;
            tick_cnt       <= 16'd0;
            ts             <= 16'd0;
            pending        <= 4'd0;
            for (int i = 0; i < 4; i++) slot_ts[i] <= 16'd0;
            rr_ptr         <= 2'd3;
            byte_idx       <= 2'd0;
            frame_b1       <= 8'd0;
            frame_b2       <= 8'd0;
            bus.tx_start   <= 1'b0;
            bus.tx_data    <= 8'd0;
            bus.frame_sent <= 1'b0;
            bus.drop_cnt   <= 8'd0;
        end else begin
            if (tick_cnt == TICK_DIV - 16'd1) begin
                tick_cnt <= 16'd0;
                ts       <= ts + 16'd1;
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
            end

            // Capture: the grant reads the old slot_ts below, so a slot
            // reloaded in the grant cycle keeps the new event pending.
            for (int i = 0; i < 4; i++) begin
                if (!bus.en) begin
                    pending[i] <= 1'b0;
                end else if (bus.req[i] && (!pending[i] || (grant && winner == 2'(i)))) begin
                    pending[i] <= 1'b1;
                    slot_ts[i] <= ts;
                end else if (grant && winner == 2'(i)) begin
                    pending[i] <= 1'b0;
                end
            end

            bus.drop_cnt   <= sat_add(bus.drop_cnt, lost);
            bus.tx_start   <= 1'b0;
            bus.frame_sent <= 1'b0;

            // tx_start is raised on entry to S_SEND so it is high exactly
            // while the FSM sits in S_SEND.
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        rr_ptr       <= winner;
                        frame_b1     <= slot_ts[winner][7:0];
                        frame_b2     <= slot_ts[winner][15:8];
                        byte_idx     <= 2'd0;
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= {HEADER, 2'b00, winner};
                        state        <= S_SEND;
                    end
                end
                S_SEND: state <= S_GAP;
                // One cycle for the transmitter to raise busy.
                S_GAP:  state <= S_WAIT;
                S_WAIT: begin
                    if (!bus.tx_busy) begin
                        if (byte_idx == 2'd2) begin
                            bus.frame_sent <= 1'b1;
                            state          <= S_IDLE;
                        end else begin
                            byte_idx     <= byte_idx + 2'd1;
                            bus.tx_start <= 1'b1;
                            bus.tx_data  <= (byte_idx == 2'd0) ? frame_b1 : frame_b2;
                            state        <= S_SEND;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_event_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_event_tx_scheduler
//   Self-checking bench for event_tx_scheduler: directed scenarios plus a
//   randomized run, compared cycle by cycle against a frame-level model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_event_tx_scheduler;
    localparam logic [15:0] TICK_DIV = 16'd2;

    logic clk_fast = 1'b0;
    logic rst      = 1'b1;

    event_tx_scheduler_if bus ();

    event_tx_scheduler #(.TICK_DIV(TICK_DIV), .HEADER(4'hA)) dut (
        .clk_fast (clk_fast),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_fast = ~clk_fast;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Transmitter stand-in: busy for a number of cycles after each start.
    int fixed_busy = 0;
    int busy_left  = 0;
    always @(negedge clk_fast) begin
        if (bus.tx_start)
            busy_left = (fixed_busy > 0) ? fixed_busy : int'($urandom_range(1, 12));
        else if (busy_left > 0)
            busy_left--;
        bus.tx_busy = (busy_left > 0);
    end

    // Reference model: pending slots, timestamp as elapsed ticks, and a frame
    // sender that emits queued bytes, each start followed by two cycles in
    // which busy is ignored, then waits for busy low.
    int          cyc = 0;
    int          m_edges = 0;
    logic [15:0] ts_base = 16'd0;
    bit          m_pend [4];
    logic [15:0] m_pts  [4];
    int          m_rr = 3;
    int          m_drops = 0;
    bit          m_inflight = 0;
    int          m_settle = 0;
    logic [7:0]  m_q [$];
    logic        m_start = 1'b0;
    logic        m_fs = 1'b0;
    logic [7:0]  m_data = 8'd0;

    function automatic logic [15:0] m_ts();
        return ts_base + 16'(m_edges / int'(TICK_DIV));
    endfunction

    always @(posedge clk_fast) begin : model
        logic [15:0] cur_ts;
        int win, lost, c;
        cyc++;
        if (rst) begin
            m_edges = 0; m_rr = 3; m_drops = 0; m_inflight = 0; m_settle = 0;
            m_q.delete(); m_start = 0; m_fs = 0; m_data = 8'd0;
            for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_pts[i] = 16'd0; end
        end else begin
            cur_ts = m_ts();
            m_edges++;
            m_start = 0; m_fs = 0; win = -1;
            if (!m_inflight) begin
                if (bus.en && !bus.tx_busy)
                    for (int k = 1; k <= 4; k++) begin
                        c = (m_rr + k) % 4;
                        if (win < 0 && m_pend[c]) win = c;
                    end
                if (win >= 0) begin
                    m_rr = win; m_pend[win] = 0;
                    m_q.delete();
                    m_q.push_back(m_pts[win][7:0]);
                    m_q.push_back(m_pts[win][15:8]);
                    m_data = {4'hA, 2'b00, 2'(win)};
                    m_start = 1; m_inflight = 1; m_settle = 2;
                end
            end else if (m_settle > 0) begin
                m_settle--;
            end else if (!bus.tx_busy) begin
                if (m_q.size() > 0) begin
                    m_data = m_q.pop_front(); m_start = 1; m_settle = 2;
                end else begin
                    m_inflight = 0; m_fs = 1;
                end
            end
            lost = 0;
            for (int i = 0; i < 4; i++)
                if (bus.en && bus.req[i]) begin
                    if (!m_pend[i]) begin m_pend[i] = 1; m_pts[i] = cur_ts; end
                    else lost++;
                end
            if (!bus.en) for (int i = 0; i < 4; i++) m_pend[i] = 0;
            m_drops = (m_drops + lost > 255) ? 255 : m_drops + lost;
        end
    end

    logic [7:0] obs [$];
    int         start_cyc [$];
    int         fs_cnt = 0;

    always @(negedge clk_fast) begin
        chk("tx_start",   bus.tx_start,   m_start);
        chk("tx_data",    bus.tx_data,    m_data);
        chk("frame_sent", bus.frame_sent, m_fs);
        chk("active",     bus.active,     m_inflight);
        chk("drop_cnt",   bus.drop_cnt,   m_drops);
        if (bus.tx_start) begin obs.push_back(bus.tx_data); start_cyc.push_back(cyc); end
        if (bus.frame_sent) fs_cnt++;
    end

    task automatic do_reset(input logic [15:0] base);
        @(negedge clk_fast);
        ts_base = base; rst = 1'b1; bus.en = 1'b1; bus.req = 4'd0;
        repeat (3) @(negedge clk_fast);
        rst = 1'b0;
        obs.delete(); start_cyc.delete(); fs_cnt = 0;
    endtask

    task automatic pulse(input logic [3:0] mask);
        bus.req = mask;
        @(negedge clk_fast);
        bus.req = 4'd0;
    endtask

    task automatic wait_bytes(input string tag, input int n, input int limit);
        for (int i = 0; i < limit && obs.size() < n; i++) @(negedge clk_fast);
        chk(tag, obs.size(), n);
    endtask

    initial begin
        logic [15:0] e, e2;
        int t0;
        bus.en = 1'b1; bus.req = 4'd0;

        // Reset state
        do_reset(16'd0);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_tx_data",  bus.tx_data, 0);
        chk("rst_fs",       bus.frame_sent, 0);
        chk("rst_active",   bus.active, 0);
        chk("rst_drop",     bus.drop_cnt, 0);

        // 1: single event at ts 0x1234, busy 10 cycles
        fixed_busy = 10;
        for (int i = 0; i < 20000 && m_ts() != 16'h1234; i++) @(negedge clk_fast);
        chk("t1_ts_reach", m_ts(), 16'h1234);
        t0 = cyc;
        pulse(4'b0001);
        wait_bytes("t1_bytes", 3, 200);
        chk("t1_b0", obs[0], 8'hA0);
        chk("t1_b1", obs[1], 8'h34);
        chk("t1_b2", obs[2], 8'h12);
        chk("t1_latency", start_cyc[0], t0 + 2);
        for (int i = 0; i < 100 && fs_cnt == 0; i++) @(negedge clk_fast);
        repeat (5) @(negedge clk_fast);
        chk("t1_fs_cnt", fs_cnt, 1);
        chk("t1_active", bus.active, 0);

        // 2: all four sources at once
        fixed_busy = 0;
        do_reset(16'd0);
        repeat (7) @(negedge clk_fast);
        e = m_ts();
        pulse(4'b1111);
        wait_bytes("t2_bytes", 12, 1000);
        for (int f = 0; f < 4; f++) begin
            chk("t2_id", obs[3*f], 8'hA0 + 8'(f));
            chk("t2_tslo", obs[3*f+1], e[7:0]);
            chk("t2_tshi", obs[3*f+2], e[15:8]);
        end
        chk("t2_drop", bus.drop_cnt, 0);

        // 3: second event on a still-pending slot is lost
        do_reset(16'd0);
        pulse(4'b0001);
        @(negedge clk_fast);
        e = m_ts();
        pulse(4'b0100);
        repeat (3) @(negedge clk_fast);
        pulse(4'b0100);
        wait_bytes("t3_bytes", 6, 1000);
        repeat (100) @(negedge clk_fast);
        chk("t3_count", obs.size(), 6);
        chk("t3_id", obs[3], 8'hA2);
        chk("t3_tslo", obs[4], e[7:0]);
        chk("t3_tshi", obs[5], e[15:8]);
        chk("t3_drop", bus.drop_cnt, 1);

        // 4: request in the grant cycle of the same source
        do_reset(16'd0);
        for (int i = 0; i < 100 && (bus.tx_busy || (m_edges % 2) != 1); i++) @(negedge clk_fast);
        e = m_ts();
        bus.req = 4'b0010;
        @(negedge clk_fast);
        e2 = m_ts();
        @(negedge clk_fast);
        bus.req = 4'd0;
        wait_bytes("t4_bytes", 6, 1000);
        chk("t4_id0", obs[0], 8'hA1);
        chk("t4_ts0", {obs[2], obs[1]}, e);
        chk("t4_id1", obs[3], 8'hA1);
        chk("t4_ts1", {obs[5], obs[4]}, e2);
        chk("t4_drop", bus.drop_cnt, 0);

        // 5: timestamp wrap
        force dut.ts = 16'hFFFF;
        do_reset(16'hFFFF);
        release dut.ts;
        chk("t5_ts_pre", dut.ts, 16'hFFFF);
        repeat (2) @(negedge clk_fast);
        chk("t5_ts_wrap", dut.ts, 16'h0000);
        pulse(4'b0100);
        wait_bytes("t5_bytes", 3, 500);
        e = obs[0];
        chk("t5_hdr", e[7:4], 4'hA);
        chk("t5_tslo", obs[1], 8'h00);
        chk("t5_tshi", obs[2], 8'h00);

        // 6: reset mid-frame, then a fresh frame; en=0 ignores requests
        fixed_busy = 10;
        do_reset(16'd0);
        pulse(4'b0001);
        for (int i = 0; i < 200 && start_cyc.size() < 2; i++) @(negedge clk_fast);
        chk("t6_second_byte", start_cyc.size(), 2);
        repeat (3) @(negedge clk_fast);
        rst = 1'b1;
        @(negedge clk_fast);
        chk("t6_tx_start", bus.tx_start, 0);
        chk("t6_tx_data",  bus.tx_data, 0);
        chk("t6_fs",       bus.frame_sent, 0);
        chk("t6_active",   bus.active, 0);
        chk("t6_drop",     bus.drop_cnt, 0);
        rst = 1'b0;
        obs.delete(); start_cyc.delete(); fs_cnt = 0;
        for (int i = 0; i < 50 && bus.tx_busy; i++) @(negedge clk_fast);
        e = m_ts();
        pulse(4'b0010);
        wait_bytes("t6_bytes", 3, 500);
        chk("t6_id", obs[0], 8'hA1);
        chk("t6_ts", {obs[2], obs[1]}, e);
        repeat (60) @(negedge clk_fast);
        bus.en = 1'b0;
        pulse(4'b1111);
        pulse(4'b1111);
        bus.en = 1'b1;
        repeat (60) @(negedge clk_fast);
        chk("t6_en0_count", obs.size(), 3);
        chk("t6_en0_drop", bus.drop_cnt, 0);

        // Randomized run against the model
        fixed_busy = 0;
        do_reset(16'd0);
        for (int i = 0; i < 4000; i++) begin
            bus.req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            bus.en  = ($urandom_range(0, 19) != 0);
            @(negedge clk_fast);
        end
        bus.req = 4'd0; bus.en = 1'b1;
        repeat (20) @(negedge clk_fast);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
